// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared lane arbiter defaults, bit positions and FSM encoding
package noc_pkg;
  localparam int NODE_COUNT         = 8;
  localparam int NODE_COUNT_DIGIT   = 3;
  localparam int ARBITER_SIGNAL_IN  = 3;
  localparam int ARBITER_SIGNAL_OUT = NODE_COUNT_DIGIT + 1;

  localparam int CTRL_SEND = 2;
  localparam int CTRL_RECV = 1;
  localparam int CTRL_BUSY = 0;
  localparam int REQ_VALID = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;
endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin search over a legal-request mask
module rr_picker #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] winner,
  output logic         found
);
  int idx;

  // Walk offsets from farthest to nearest so the first hit after rr_ptr wins last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N;
      if (mask[idx]) begin
        winner = idx[W-1:0];
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lane_arbiter.sv
// rtl/lane_arbiter.sv - one-direction lane arbiter: round-robin grant, timed hold, turnaround
module lane_arbiter #(
  parameter int NODE_COUNT         = noc_pkg::NODE_COUNT,
  parameter int NODE_COUNT_DIGIT   = noc_pkg::NODE_COUNT_DIGIT,
  parameter int ARBITER_SIGNAL_IN  = noc_pkg::ARBITER_SIGNAL_IN,
  parameter int ARBITER_SIGNAL_OUT = NODE_COUNT_DIGIT + 1,
  parameter int LANE_DIRECTION     = 0,
  parameter int HOLD_CYCLES        = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NODE_COUNT*ARBITER_SIGNAL_OUT-1:0] request_in,
  output logic [NODE_COUNT*ARBITER_SIGNAL_IN-1:0]  control_out,
  output logic [NODE_COUNT_DIGIT-1:0]             grant_node
);
  import noc_pkg::*;

  localparam int NW = NODE_COUNT_DIGIT;
  localparam int CW = NODE_COUNT * ARBITER_SIGNAL_IN;

  state_e        state_q, state_d;
  logic [NW-1:0] winner_q, winner_d;
  logic [NW-1:0] dest_q, dest_d;
  logic [NW-1:0] rr_q, rr_d;
  logic [3:0]    hold_q, hold_d;
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic [NW-1:0] grant_q, grant_d;

  logic [NW-1:0]         req_dest [NODE_COUNT];
  logic [NODE_COUNT-1:0] req_valid;
  logic [NODE_COUNT-1:0] legal;
  logic [NW-1:0]         pick;
  logic                  found;

  for (genvar i = 0; i < NODE_COUNT; i++) begin : g_req
    assign req_dest[i]  = request_in[i*ARBITER_SIGNAL_OUT +: NW];
    assign req_valid[i] = request_in[i*ARBITER_SIGNAL_OUT + REQ_VALID];
    assign legal[i] = req_valid[i] && (int'(req_dest[i]) != i) &&
                      (int'(req_dest[i]) < NODE_COUNT) &&
                      ((LANE_DIRECTION == 0) ? (int'(req_dest[i]) > i)
                                             : (int'(req_dest[i]) < i));
  end

  rr_picker #(.N(NODE_COUNT), .W(NW)) u_picker (
    .mask   (legal),
    .rr_ptr (rr_q),
    .winner (pick),
    .found  (found)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      winner_q <= '0;
      dest_q   <= '0;
      rr_q     <= '0;
      hold_q   <= '0;
      ctrl_q   <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      dest_q   <= dest_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      ctrl_q   <= ctrl_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    dest_d   = dest_q;
    rr_d     = rr_q;
    hold_d   = hold_q;
    case (state_q)
      ST_GRANT: begin
        // A dropped valid from the sender aborts the hold early.
        if (!req_valid[winner_q] || hold_q == 4'd0) begin
          state_d = ST_RELEASE;
          hold_d  = 4'd0;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: begin
        if (found) begin
          state_d  = ST_GRANT;
          winner_d = pick;
          dest_d   = req_dest[pick];
          rr_d     = (pick == NW'(NODE_COUNT - 1)) ? '0 : pick + NW'(1);
          hold_d   = 4'(HOLD_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
          hold_d  = 4'd0;
        end
      end
    endcase
  end

  always_comb begin
    ctrl_d  = '0;
    grant_d = grant_q;
    if (state_d == ST_GRANT) begin
      grant_d = winner_d;
      for (int i = 0; i < NODE_COUNT; i++) begin
        ctrl_d[i*ARBITER_SIGNAL_IN + CTRL_BUSY] = 1'b1;
        if (NW'(i) == winner_d) ctrl_d[i*ARBITER_SIGNAL_IN + CTRL_SEND] = 1'b1;
        if (NW'(i) == dest_d)   ctrl_d[i*ARBITER_SIGNAL_IN + CTRL_RECV] = 1'b1;
      end
    end
  end

  assign control_out = ctrl_q;
  assign grant_node  = grant_q;
endmodule

// File: tb/tb_lane_arbiter.sv
// tb/tb_lane_arbiter.sv - directed table-driven bench for lane_arbiter
module tb_lane_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] req1 = '0;
  logic [31:0] req3 = '0;
  logic [23:0] ctrl1, ctrl3;
  logic [2:0]  grant1, grant3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lane_arbiter #(.LANE_DIRECTION(0), .HOLD_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .request_in(req1),
    .control_out(ctrl1), .grant_node(grant1)
  );

  lane_arbiter #(.LANE_DIRECTION(0), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .request_in(req3),
    .control_out(ctrl3), .grant_node(grant3)
  );

  typedef struct {
    logic [31:0] req;
    logic [23:0] ctrl;
    logic [2:0]  g;
    bit          chk_g;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rq(input int n, input int d);
    logic [31:0] r;
    r = '0;
    r[n*4 +: 4] = {1'b1, 3'(d)};
    return r;
  endfunction

  function automatic logic [23:0] mk(input int s, input int d);
    logic [23:0] c;
    for (int i = 0; i < 8; i++) c[i*3 +: 3] = 3'b001;
    c[s*3 +: 3] = 3'b101;
    c[d*3 +: 3] = 3'b011;
    return c;
  endfunction

  function automatic int count_bit(input logic [23:0] c, input int b);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(c[i*3 + b]);
    return n;
  endfunction

  task automatic add(input logic [31:0] r, input logic [23:0] c, input int g, input bit cg);
    vec_t v;
    v.req = r; v.ctrl = c; v.g = 3'(g); v.chk_g = cg;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    step();
    check("reset_ctrl", 32'(ctrl1), 32'h0);
    check("reset_grant", 32'(grant1), 32'h0);
    check("reset_ctrl3", 32'(ctrl3), 32'h0);
    reset = 1'b1;

    // Round-robin order from rr_ptr=0, then prove rr_ptr advanced to 4
    add(rq(1,4) | rq(3,6), mk(1,4), 1, 1);
    add(rq(1,4) | rq(3,6), 24'h0,   0, 0);
    add(rq(1,4) | rq(3,6), mk(3,6), 3, 1);
    add(32'h0,             24'h0,   0, 0);
    add(32'h0,             24'h0,   0, 0);
    add(rq(2,3) | rq(4,5), mk(4,5), 4, 1);
    add(32'h0,             24'h0,   0, 0);
    add(32'h0,             24'h0,   0, 0);
    // Single request
    add(rq(2,5),           mk(2,5), 2, 1);
    add(32'h0,             24'h0,   0, 0);
    add(32'h0,             24'h0,   0, 0);
    // Wrap-around: rr_ptr=6 after node 5, node 1 beats node 3
    add(rq(5,7),           mk(5,7), 5, 1);
    add(32'h0,             24'h0,   0, 0);
    add(rq(1,2) | rq(3,4), mk(1,2), 1, 1);
    add(rq(1,2) | rq(3,4), 24'h0,   0, 0);
    add(rq(1,2) | rq(3,4), mk(3,4), 3, 1);
    add(32'h0,             24'h0,   0, 0);
    add(32'h0,             24'h0,   0, 0);
    // Illegal requests: wrong direction, self, self, and a non-valid one
    add(rq(6,2) | rq(4,4) | rq(7,7), 24'h0, 0, 0);
    add(rq(6,2) | rq(4,4) | rq(7,7) | 32'h0000_0005, 24'h0, 0, 0);
    add(32'h0,             24'h0,   0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      req1 = vecs[i].req;
      step();
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl1), 32'(vecs[i].ctrl));
      if (vecs[i].chk_g) check($sformatf("vec%0d_grant", i), 32'(grant1), 32'(vecs[i].g));
      check($sformatf("vec%0d_send_onehot", i), 32'(count_bit(ctrl1, 2) > 1), 32'h0);
      check($sformatf("vec%0d_recv_onehot", i), 32'(count_bit(ctrl1, 1) > 1), 32'h0);
    end

    // HOLD_CYCLES=3: abort when the sender drops valid
    req3 = rq(0,1);
    step();
    check("abort_grant", 32'(ctrl3), 32'(mk(0,1)));
    check("abort_grant_node", 32'(grant3), 32'h0);
    req3 = '0;
    step();
    check("abort_release", 32'(ctrl3), 32'h0);
    step();
    check("abort_idle", 32'(ctrl3), 32'h0);

    // Full hold of 3 cycles; destination stays latched when request changes
    req3 = rq(2,6);
    step();
    check("hold_c1", 32'(ctrl3), 32'(mk(2,6)));
    req3 = rq(2,7) | rq(3,7);
    step();
    check("hold_c2", 32'(ctrl3), 32'(mk(2,6)));
    step();
    check("hold_c3", 32'(ctrl3), 32'(mk(2,6)));
    check("hold_c3_grant", 32'(grant3), 32'h2);
    req3 = '0;
    step();
    check("hold_release", 32'(ctrl3), 32'h0);
    step();

    // Reset mid-GRANT clears outputs without a clock edge; rr restarts at 0
    req3 = rq(0,1);
    step();
    check("rst_pre_grant", 32'(ctrl3), 32'(mk(0,1)));
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_ctrl", 32'(ctrl3), 32'h0);
    check("rst_async_grant", 32'(grant3), 32'h0);
    req3 = rq(0,1) | rq(2,6);
    step();
    check("rst_held_ctrl", 32'(ctrl3), 32'h0);
    reset = 1'b1;
    step();
    check("rst_restart_ctrl", 32'(ctrl3), 32'(mk(0,1)));
    check("rst_restart_grant", 32'(grant3), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lane_arbiter.md
LANE_ARBITER -- requirements
Module: lane_arbiter

Interface
REQ-001 Parameter NODE_COUNT, default 8: number of nodes attached to the lane.
REQ-002 Parameter NODE_COUNT_DIGIT, default 3: address width, equal to clog2(NODE_COUNT).
REQ-003 Parameter ARBITER_SIGNAL_IN, default 3: per-node control width driven by the arbiter.
REQ-004 Parameter ARBITER_SIGNAL_OUT, default NODE_COUNT_DIGIT+1: per-node request width received by the arbiter.
REQ-005 Parameter LANE_DIRECTION, default 0: 0 means the low-to-high lane (dest > source); 1 means the high-to-low lane (dest < source).
REQ-006 Parameter HOLD_CYCLES, default 1, range 1..15: number of cycles the bus is granted per transfer.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 reset  input  1  asynchronous, active-low; reset==0 forces the reset state immediately.
REQ-009 request_in  input  NODE_COUNT*ARBITER_SIGNAL_OUT  node i occupies slice [i*4+3:i*4]; bit 3 = request valid, bits 2:0 = destination address.
REQ-010 control_out  output  NODE_COUNT*ARBITER_SIGNAL_IN  node i occupies slice [i*3+2:i*3]; bit 2 = send grant, bit 1 = receive enable, bit 0 = bus busy.
REQ-011 grant_node  output  NODE_COUNT_DIGIT  index of the current sender; valid while the FSM is in GRANT.

Function
REQ-012 A request from node i shall be legal only if it is valid, its dest differs from i, dest < NODE_COUNT, and dest lies on the correct side of i per LANE_DIRECTION; illegal requests shall be ignored, with no error output.
REQ-013 FSM states: IDLE, GRANT, RELEASE. All outputs registered.
REQ-014 IDLE: at each edge, if any legal request exists, pick a winner round-robin starting at rr_ptr and go to GRANT; otherwise stay in IDLE with all control_out = 0.
REQ-015 GRANT, sender bits: winner slice = 3'b101.
REQ-016 GRANT, receiver bits: destination slice = 3'b011.
REQ-017 GRANT, other nodes: every other slice = 3'b001.
REQ-018 GRANT, duration: outputs held for exactly HOLD_CYCLES cycles using a hold counter.
REQ-019 GRANT, next state: after the last hold cycle, go to RELEASE.
REQ-020 Winner and destination are latched on entry to GRANT and shall not change in GRANT, even if request_in changes.
REQ-021 If the winner's valid bit drops during GRANT, the next edge shall enter RELEASE (abort); the hold counter is discarded.
REQ-022 RELEASE lasts one cycle with all control_out = 0 (bus turnaround).
REQ-023 From RELEASE, the next edge arbitrates exactly as IDLE does and goes to GRANT if any legal request exists, else to IDLE.
REQ-024 rr_ptr shall update to (winner+1) mod NODE_COUNT on entry to GRANT, wrapping from NODE_COUNT-1 to 0; the search order is rr_ptr, rr_ptr+1, ... with wrap.
REQ-025 Latency: a legal request sampled at edge k (in IDLE) shall produce grant controls valid immediately after edge k.
REQ-026 At no time shall more than one slice have bit 2 set, and at no time shall more than one slice have bit 1 set.

Reset
REQ-027 While reset==0: state = IDLE, control_out = 0, grant_node = 0, rr_ptr = 0, hold counter = 0.
REQ-028 Reset asserted mid-GRANT shall clear all control_out asynchronously, with no RELEASE cycle.
REQ-029 After reset deasserts, arbitration restarts from node 0.

Structure
REQ-030 Package noc_pkg shall hold the NODE_COUNT, NODE_COUNT_DIGIT, ARBITER_SIGNAL_IN and ARBITER_SIGNAL_OUT defaults, the control bit positions (SEND=2, RECV=1, BUSY=0), the request valid bit position (3), and the FSM state encoding.
REQ-031 Sub-module rr_picker (combinational: legal-request mask plus rr_ptr in, winner index and found flag out) shall implement the round-robin search; lane_arbiter owns all state.

Verification (LANE_DIRECTION=0, HOLD_CYCLES=1, NODE_COUNT=8)
REQ-032 Single request: node 2 request = 4'b1101 (dest 5) -> next cycle node2 = 101, node5 = 011, others = 001, grant_node = 2; then one cycle all 000; then IDLE.
REQ-033 Round-robin order: rr_ptr = 0, nodes 1 (dest 4) and 3 (dest 6) held -> grants 1, RELEASE, 3, RELEASE; rr_ptr ends at 4.
REQ-034 Wrap-around: grant node 5 (dest 7) so rr_ptr = 6, then nodes 1 (dest 2) and 3 (dest 4) request -> node 1 granted first.
REQ-035 Illegal requests: node 6 dest 2, node 4 dest 4, and node 7 dest 7 -> control_out stays all 0 and state stays IDLE.
REQ-036 Abort and reset: HOLD_CYCLES=3, node 0 (dest 1) granted, valid dropped after 1 cycle -> RELEASE on the next edge. Repeat with reset pulled low mid-GRANT -> control_out = 0 without waiting for a clock edge, and rr_ptr = 0.
